// File: rtl/guess_hint_evaluator.sv
// Mastermind hint scorer: counts exact (green) and colour-only (yellow)
// matches of a latched guess against a latched secret, one pin per cycle.
module guess_hint_evaluator #(
  parameter int PIN_COLOR_W = 5,
  parameter int PIN_POS_W   = 5,
  parameter int MAX_PINS    = 20
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic                            start,
  input  logic [PIN_POS_W-1:0]            pins_count,
  input  logic [MAX_PINS*PIN_COLOR_W-1:0] guess,
  input  logic [MAX_PINS*PIN_COLOR_W-1:0] secret,
  output logic                            busy,
  output logic                            done,
  output logic [PIN_POS_W-1:0]            green,
  output logic [PIN_POS_W-1:0]            yellow,
  output logic [MAX_PINS-1:0]             analyzed_guess,
  output logic [MAX_PINS-1:0]             analyzed_secret
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GREEN,
    S_YELLOW,
    S_DONE
  } state_t;

  localparam logic [PIN_POS_W-1:0] MaxN = PIN_POS_W'(MAX_PINS);

  state_t                          state_q, state_d;
  logic [MAX_PINS*PIN_COLOR_W-1:0] guess_q, guess_d;
  logic [MAX_PINS*PIN_COLOR_W-1:0] secret_q, secret_d;
  logic [PIN_POS_W-1:0]            n_q, n_d;
  logic [PIN_POS_W-1:0]            i_q, i_d;
  logic [PIN_POS_W-1:0]            green_q, green_d;
  logic [PIN_POS_W-1:0]            yellow_q, yellow_d;
  logic [MAX_PINS-1:0]             ag_q, ag_d;
  logic [MAX_PINS-1:0]             as_q, as_d;

  logic [PIN_COLOR_W-1:0] g_pin [MAX_PINS];
  logic [PIN_COLOR_W-1:0] s_pin [MAX_PINS];

  for (genvar k = 0; k < MAX_PINS; k++) begin : g_unpack
    assign g_pin[k] = guess_q[k*PIN_COLOR_W +: PIN_COLOR_W];
    assign s_pin[k] = secret_q[k*PIN_COLOR_W +: PIN_COLOR_W];
  end

  logic [PIN_POS_W-1:0] n_clamp;
  logic                 last;
  logic                 hit;
  logic [PIN_POS_W-1:0] hit_j;

  assign n_clamp = (pins_count > MaxN) ? MaxN : pins_count;
  assign last    = (i_q == n_q - 1'b1);

  // Descending scan so the lowest free matching secret pin wins.
  always_comb begin
    hit   = 1'b0;
    hit_j = '0;
    for (int j = MAX_PINS - 1; j >= 0; j--) begin
      if (j < int'(n_q) && !as_q[j] && s_pin[j] == g_pin[i_q]) begin
        hit   = 1'b1;
        hit_j = PIN_POS_W'(j);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    secret_d = secret_q;
    n_d      = n_q;
    i_d      = i_q;
    green_d  = green_q;
    yellow_d = yellow_q;
    ag_d     = ag_q;
    as_d     = as_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          guess_d  = guess;
          secret_d = secret;
          n_d      = n_clamp;
          i_d      = '0;
          green_d  = '0;
          yellow_d = '0;
          ag_d     = '0;
          as_d     = '0;
          state_d  = (n_clamp != '0) ? S_GREEN : S_DONE;
        end
      end
      S_GREEN: begin
        if (g_pin[i_q] == s_pin[i_q]) begin
          green_d  = green_q + 1'b1;
          ag_d[i_q] = 1'b1;
          as_d[i_q] = 1'b1;
        end
        if (last) begin
          i_d     = '0;
          state_d = S_YELLOW;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      S_YELLOW: begin
        if (!ag_q[i_q] && hit) begin
          yellow_d    = yellow_q + 1'b1;
          ag_d[i_q]   = 1'b1;
          as_d[hit_j] = 1'b1;
        end
        if (last) begin
          i_d     = '0;
          state_d = S_DONE;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= S_IDLE;
      guess_q  <= '0;
      secret_q <= '0;
      n_q      <= '0;
      i_q      <= '0;
      green_q  <= '0;
      yellow_q <= '0;
      ag_q     <= '0;
      as_q     <= '0;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      secret_q <= secret_d;
      n_q      <= n_d;
      i_q      <= i_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      ag_q     <= ag_d;
      as_q     <= as_d;
    end
  end

  assign busy            = (state_q == S_GREEN) || (state_q == S_YELLOW);
  assign done            = (state_q == S_DONE);
  assign green           = green_q;
  assign yellow          = yellow_q;
  assign analyzed_guess  = ag_q;
  assign analyzed_secret = as_q;

endmodule

// File: tb/tb_guess_hint_evaluator.sv
// Bench for guess_hint_evaluator: directed and random games scored
// against a colour-counting reference model.
module tb_guess_hint_evaluator;

  localparam int CW = 5;
  localparam int PW = 5;
  localparam int MP = 20;
  localparam int VW = MP * CW;

  logic          clk;
  logic          nrst;
  logic          start;
  logic [PW-1:0] pins_count;
  logic [VW-1:0] guess;
  logic [VW-1:0] secret;
  logic          busy;
  logic          done;
  logic [PW-1:0] green;
  logic [PW-1:0] yellow;
  logic [MP-1:0] analyzed_guess;
  logic [MP-1:0] analyzed_secret;

  int checks = 0;
  int errors = 0;

  guess_hint_evaluator #(
    .PIN_COLOR_W(CW),
    .PIN_POS_W  (PW),
    .MAX_PINS   (MP)
  ) dut (
    .clk            (clk),
    .nrst           (nrst),
    .start          (start),
    .pins_count     (pins_count),
    .guess          (guess),
    .secret         (secret),
    .busy           (busy),
    .done           (done),
    .green          (green),
    .yellow         (yellow),
    .analyzed_guess (analyzed_guess),
    .analyzed_secret(analyzed_secret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mastermind rules by colour counting: greens first, then per colour
  // min(unmatched guess count, unmatched secret count) yellows; the
  // earliest unmatched pins of each colour are the ones consumed.
  task automatic model(input logic [VW-1:0] g, input logic [VW-1:0] s,
                       input int n, output int gr, output int ye,
                       output logic [MP-1:0] ag, output logic [MP-1:0] as);
    int cg [32];
    int cs [32];
    int qg [32];
    int qs [32];
    int gc, sc, m;
    gr = 0;
    ye = 0;
    ag = '0;
    as = '0;
    for (int c = 0; c < 32; c++) begin
      cg[c] = 0;
      cs[c] = 0;
    end
    for (int k = 0; k < n; k++) begin
      gc = int'(g[k*CW +: CW]);
      sc = int'(s[k*CW +: CW]);
      if (gc == sc) begin
        gr++;
        ag[k] = 1'b1;
        as[k] = 1'b1;
      end else begin
        cg[gc]++;
        cs[sc]++;
      end
    end
    for (int c = 0; c < 32; c++) begin
      m = (cg[c] < cs[c]) ? cg[c] : cs[c];
      ye += m;
      qg[c] = m;
      qs[c] = m;
    end
    for (int k = 0; k < n; k++) begin
      gc = int'(g[k*CW +: CW]);
      sc = int'(s[k*CW +: CW]);
      if (gc != sc && qg[gc] > 0) begin
        ag[k] = 1'b1;
        qg[gc]--;
      end
      if (gc != sc && qs[sc] > 0) begin
        as[k] = 1'b1;
        qs[sc]--;
      end
    end
  endtask

  function automatic logic [VW-1:0] pk4(input int a, input int b,
                                        input int c, input int d);
    logic [VW-1:0] v;
    v = '0;
    v[0*CW +: CW] = CW'(a);
    v[1*CW +: CW] = CW'(b);
    v[2*CW +: CW] = CW'(c);
    v[3*CW +: CW] = CW'(d);
    return v;
  endfunction

  function automatic logic [VW-1:0] rnd_vec(input int maxc);
    logic [VW-1:0] v;
    for (int k = 0; k < MP; k++) v[k*CW +: CW] = CW'($urandom_range(0, maxc));
    return v;
  endfunction

  // One evaluation: start sampled at edge 0, then every cycle up to the
  // expected done cycle is checked, plus two hold cycles after it.
  task automatic run(input string tag, input int pc,
                     input logic [VW-1:0] g, input logic [VW-1:0] s,
                     input int dup_cycle);
    int n, gr, ye, last_c;
    logic [MP-1:0] ag, as;
    n = (pc > MP) ? MP : pc;
    model(g, s, n, gr, ye, ag, as);
    last_c = 2 * n + 1;
    @(negedge clk);
    pins_count = PW'(pc);
    guess      = g;
    secret     = s;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    guess  = rnd_vec(7);
    secret = rnd_vec(7);
    for (int cyc = 1; cyc <= last_c + 2; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk);
        #1;
      end
      if (cyc == 1) begin
        check({tag, ":clr_g"}, 32'(green), 32'(0));
        check({tag, ":clr_ag"}, 32'(analyzed_guess & ~ag), 32'(0));
      end
      start = (cyc == dup_cycle);
      if (cyc == dup_cycle) begin
        pins_count = PW'($urandom_range(1, 20));
        guess      = rnd_vec(3);
        secret     = rnd_vec(3);
      end
      check({tag, ":busy"}, 32'(busy), 32'(cyc <= 2 * n));
      check({tag, ":done"}, 32'(done), 32'(cyc == last_c));
      if (cyc >= last_c) begin
        check({tag, ":green"}, 32'(green), 32'(gr));
        check({tag, ":yellow"}, 32'(yellow), 32'(ye));
        check({tag, ":ag"}, 32'(analyzed_guess), 32'(ag));
        check({tag, ":as"}, 32'(analyzed_secret), 32'(as));
      end
    end
    start = 1'b0;
  endtask

  initial begin
    logic [VW-1:0] v;
    nrst       = 1'b0;
    start      = 1'b0;
    pins_count = '0;
    guess      = '0;
    secret     = '0;
    #12;
    check("rst:busy", 32'(busy), 32'(0));
    check("rst:done", 32'(done), 32'(0));
    check("rst:green", 32'(green), 32'(0));
    check("rst:yellow", 32'(yellow), 32'(0));
    check("rst:masks", 32'({analyzed_guess, analyzed_secret} != '0), 32'(0));
    @(negedge clk);
    nrst = 1'b1;

    run("exact", 4, pk4(0, 1, 2, 3), pk4(0, 1, 2, 3), 0);
    run("rev", 4, pk4(3, 2, 1, 0), pk4(0, 1, 2, 3), 0);
    run("dup1", 4, pk4(3, 2, 2, 2), pk4(2, 3, 3, 3), 0);
    run("dup2", 4, pk4(0, 1, 0, 5), pk4(0, 0, 1, 1), 0);
    run("n0", 0, pk4(1, 1, 1, 1), pk4(1, 1, 1, 1), 0);
    v = '0;
    for (int k = 0; k < MP; k++) v[k*CW +: CW] = CW'(20);
    run("clamp", 31, v, v, 0);
    run("dupstart", 6, rnd_vec(3), rnd_vec(3), 3);

    @(negedge clk);
    pins_count = PW'(8);
    guess      = rnd_vec(3);
    secret     = rnd_vec(3);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    nrst = 1'b0;
    #1;
    check("midrst:busy", 32'(busy), 32'(0));
    check("midrst:done", 32'(done), 32'(0));
    check("midrst:green", 32'(green), 32'(0));
    check("midrst:yellow", 32'(yellow), 32'(0));
    check("midrst:masks", 32'({analyzed_guess, analyzed_secret} != '0), 32'(0));
    @(negedge clk);
    nrst = 1'b1;
    run("after_rst", 4, pk4(0, 1, 0, 5), pk4(0, 0, 1, 1), 0);

    for (int t = 0; t < 40; t++) begin
      run("rand", $urandom_range(0, 31), rnd_vec(t % 8), rnd_vec(t % 8), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
